// File: rtl/scope_capture_buffer.sv
// Oscilloscope capture buffer: circular sample RAM with pre/post-trigger record and valid/ready readout.
// Optional auto-trigger on timeout is enabled by defining SCOPE_AUTO_TRIG_EN.
module scope_capture_buffer #(
    parameter int ADDR_W       = 10,
    parameter int PRE_SAMPLES  = 256,
    parameter int AUTO_TIMEOUT = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] sample_in,
    input  logic       sample_en,
    input  logic       arm,
    input  logic       abort,
    input  logic [7:0] trig_level,
    input  logic       trig_rising,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    input  logic       rd_ready,
    output logic       rd_last,
    output logic       busy,
    output logic       triggered,
    output logic       auto_trig
);

    localparam int DEPTH  = 1 << ADDR_W;
    localparam int POST_N = DEPTH - PRE_SAMPLES - 1;
    localparam int CNT_W  = ADDR_W + 1;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] PREFILL   = 3'd1;
    localparam logic [2:0] WAIT_TRIG = 3'd2;
    localparam logic [2:0] POST      = 3'd3;
    localparam logic [2:0] READ      = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        prev_q, prev_d;
    logic [7:0]        rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              rd_last_q, rd_last_d;
    logic              triggered_q, triggered_d;
    logic              auto_trig_q, auto_trig_d;
    logic              ram_we;
    logic              rise_hit, fall_hit, real_hit;
    logic              timeout;

    logic [7:0] mem [0:DEPTH-1];

    assign rise_hit = (prev_q < trig_level) && (sample_in >= trig_level);
    assign fall_hit = (prev_q > trig_level) && (sample_in <= trig_level);
    assign real_hit = trig_rising ? rise_hit : fall_hit;

`ifdef SCOPE_AUTO_TRIG_EN
    localparam int TMO_W = $clog2(AUTO_TIMEOUT + 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;

    assign timeout = (tmo_q == TMO_W'(AUTO_TIMEOUT));

    // Saturating wait counter; restarts whenever the capture leaves WAIT_TRIG.
    always_comb begin
        tmo_d = '0;
        if (state_q == WAIT_TRIG && state_d == WAIT_TRIG) begin
            tmo_d = timeout ? tmo_q : tmo_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    logic unused_auto;

    assign timeout     = 1'b0;
    assign unused_auto = (AUTO_TIMEOUT > 0);
`endif

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_addr_d   = rd_addr_q;
        cnt_d       = cnt_q;
        prev_d      = prev_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = rd_valid_q;
        rd_last_d   = rd_last_q;
        triggered_d = triggered_q;
        auto_trig_d = auto_trig_q;
        ram_we      = 1'b0;

        case (state_q)
            IDLE: begin
                if (arm) begin
                    state_d     = PREFILL;
                    wr_ptr_d    = '0;
                    cnt_d       = '0;
                    triggered_d = 1'b0;
                    auto_trig_d = 1'b0;
                end
            end
            PREFILL: begin
                if (sample_en) begin
                    ram_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    prev_d   = sample_in;
                    if (cnt_q == CNT_W'(PRE_SAMPLES - 1)) begin
                        cnt_d   = '0;
                        state_d = WAIT_TRIG;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            WAIT_TRIG: begin
                if (sample_en) begin
                    ram_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    prev_d   = sample_in;
                    // The record start is fixed here so POST never needs the trigger address.
                    if (real_hit || timeout) begin
                        triggered_d = 1'b1;
                        auto_trig_d = !real_hit;
                        rd_addr_d   = wr_ptr_q - ADDR_W'(PRE_SAMPLES);
                        cnt_d       = '0;
                        state_d     = (POST_N == 0) ? READ : POST;
                    end
                end
            end
            POST: begin
                if (sample_en) begin
                    ram_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    prev_d   = sample_in;
                    if (cnt_q == CNT_W'(POST_N - 1)) begin
                        cnt_d   = '0;
                        state_d = READ;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            READ: begin
                // The output register doubles as the RAM read register; refill it whenever it empties or drains.
                if (!rd_valid_q || rd_ready) begin
                    if (cnt_q != CNT_W'(DEPTH)) begin
                        rd_data_d  = mem[rd_addr_q];
                        rd_valid_d = 1'b1;
                        rd_last_d  = (cnt_q == CNT_W'(DEPTH - 1));
                        rd_addr_d  = rd_addr_q + 1'b1;
                        cnt_d      = cnt_q + 1'b1;
                    end else begin
                        rd_valid_d = 1'b0;
                        rd_last_d  = 1'b0;
                        cnt_d      = '0;
                        state_d    = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort) begin
            state_d     = IDLE;
            ram_we      = 1'b0;
            rd_valid_d  = 1'b0;
            rd_last_d   = 1'b0;
            triggered_d = 1'b0;
            auto_trig_d = 1'b0;
            cnt_d       = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[wr_ptr_q] <= sample_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_addr_q   <= '0;
            cnt_q       <= '0;
            prev_q      <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            triggered_q <= 1'b0;
            auto_trig_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_addr_q   <= rd_addr_d;
            cnt_q       <= cnt_d;
            prev_q      <= prev_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            rd_last_q   <= rd_last_d;
            triggered_q <= triggered_d;
            auto_trig_q <= auto_trig_d;
        end
    end

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign rd_last   = rd_last_q;
    assign busy      = (state_q != IDLE);
    assign triggered = triggered_q;
    assign auto_trig = auto_trig_q;

endmodule

// File: tb/tb_scope_capture_buffer.sv
// Directed self-checking bench for scope_capture_buffer with a 16-deep record and 4 pre-trigger samples.
// Covers the auto-trigger path when SCOPE_AUTO_TRIG_EN is defined, the indefinite wait otherwise.
module tb_scope_capture_buffer;

    localparam int ADDR_W = 4;
    localparam int PRE    = 4;
    localparam int TMO    = 32;
    localparam int NBEATS = 16;
`ifdef SCOPE_AUTO_TRIG_EN
    localparam int FALL_START = 120;
`else
    localparam int FALL_START = 255;
`endif

    logic       clk = 1'b0;
    logic       rstN;
    logic [7:0] sampleIn;
    logic       sampleEn;
    logic       arm;
    logic       abort;
    logic [7:0] trigLevel;
    logic       trigRising;
    logic [7:0] rdData;
    logic       rdValid;
    logic       rdReady;
    logic       rdLast;
    logic       busy;
    logic       triggered;
    logic       autoTrig;

    int         checkCount = 0;
    int         errorCount = 0;
    logic [7:0] expBeats [NBEATS];

    scope_capture_buffer #(
        .ADDR_W      (ADDR_W),
        .PRE_SAMPLES (PRE),
        .AUTO_TIMEOUT(TMO)
    ) dut (
        .clk        (clk),
        .rst_n      (rstN),
        .sample_in  (sampleIn),
        .sample_en  (sampleEn),
        .arm        (arm),
        .abort      (abort),
        .trig_level (trigLevel),
        .trig_rising(trigRising),
        .rd_data    (rdData),
        .rd_valid   (rdValid),
        .rd_ready   (rdReady),
        .rd_last    (rdLast),
        .busy       (busy),
        .triggered  (triggered),
        .auto_trig  (autoTrig)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] value);
        sampleIn = value;
        sampleEn = 1'b1;
        stepCycle();
        sampleEn = 1'b0;
    endtask

    task automatic armCapture();
        arm = 1'b1;
        stepCycle();
        arm = 1'b0;
        checkOutput("busy_after_arm", busy, 1);
    endtask

    // Drains one record, checking order, rd_last placement and stability across stalls.
    task automatic readRecord(input bit toggleReady);
        int         beat = 0;
        int         cyc = 0;
        logic       held = 1'b0;
        logic [8:0] heldVal = '0;
        while (beat < NBEATS && cyc < 200) begin
            rdReady = toggleReady ? (cyc % 2 == 0) : 1'b1;
            if (held) checkOutput("stall_hold", {rdValid, rdLast, rdData}, {1'b1, heldVal});
            held    = rdValid && !rdReady;
            heldVal = {rdLast, rdData};
            if (rdValid && rdReady) begin
                checkOutput("beat_data", rdData, expBeats[beat]);
                checkOutput("beat_last", rdLast, beat == NBEATS - 1);
                beat++;
            end
            stepCycle();
            cyc++;
        end
        rdReady = 1'b1;
        checkOutput("beats_seen", beat, NBEATS);
        checkOutput("idle_after_read", {busy, rdValid}, 0);
    endtask

    initial begin
        int  n;
        bit  seenValid;
        bit  lostBusy;

        rstN       = 1'b0;
        arm        = 1'b0;
        abort      = 1'b0;
        sampleEn   = 1'b0;
        sampleIn   = '0;
        trigLevel  = '0;
        trigRising = 1'b1;
        rdReady    = 1'b1;
        repeat (3) stepCycle();
        checkOutput("reset_outputs", {rdData, rdValid, rdLast, busy, triggered, autoTrig}, 0);
        rstN = 1'b1;
        stepCycle();
        checkOutput("idle_busy", busy, 0);

        // Rising ramp, trigger at 10: record 6..21
        trigLevel  = 8'd10;
        trigRising = 1'b1;
        armCapture();
        for (int v = 0; v <= 21; v++) begin
            applyStimulus(8'(v));
            checkOutput("rise_trig", triggered, v >= 10);
        end
        for (int i = 0; i < NBEATS; i++) expBeats[i] = 8'(6 + i);
        readRecord(1'b0);

        // Reset pulse in the middle of POST
        armCapture();
        for (int v = 0; v <= 13; v++) applyStimulus(8'(v));
        checkOutput("pre_reset_trig", triggered, 1);
        rstN = 1'b0;
        stepCycle();
        checkOutput("reset_mid_post", {rdData, rdValid, rdLast, busy, triggered, autoTrig}, 0);
        rstN = 1'b1;
        stepCycle();
        checkOutput("idle_after_reset", busy, 0);

        // Falling ramp, trigger at 100: record 104..89
        trigLevel  = 8'd100;
        trigRising = 1'b0;
        armCapture();
        for (int v = FALL_START; v >= 89; v--) begin
            applyStimulus(8'(v));
            checkOutput("fall_trig", triggered, v <= 100);
        end
        for (int i = 0; i < NBEATS; i++) expBeats[i] = 8'(104 - i);
        readRecord(1'b0);

        // Crossing inside prefill is ignored; later crossing fires; read with stalls
        trigLevel  = 8'd2;
        trigRising = 1'b1;
        armCapture();
        begin
            logic [7:0] seqVals [10];
            seqVals = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd0, 8'd0, 8'd0, 8'd1};
            for (int i = 0; i < 10; i++) begin
                applyStimulus(seqVals[i]);
                checkOutput("prefill_no_trig", triggered, 0);
            end
        end
        applyStimulus(8'd2);
        checkOutput("late_trig", triggered, 1);
        checkOutput("late_trig_auto", autoTrig, 0);
        for (int v = 3; v <= 13; v++) applyStimulus(8'(v));
        for (int i = 0; i < NBEATS; i++) expBeats[i] = (i < 3) ? 8'd0 : 8'(i - 2);
        readRecord(1'b1);

        // Abort during POST
        trigLevel = 8'd10;
        armCapture();
        for (int v = 0; v <= 13; v++) applyStimulus(8'(v));
        abort = 1'b1;
        stepCycle();
        abort = 1'b0;
        checkOutput("abort_state", {busy, rdValid, rdLast, triggered}, 0);
        seenValid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            stepCycle();
            if (rdValid || busy) seenValid = 1'b1;
        end
        checkOutput("abort_quiet", seenValid, 0);

        // Arm together with abort: abort wins
        arm   = 1'b1;
        abort = 1'b1;
        stepCycle();
        arm   = 1'b0;
        abort = 1'b0;
        checkOutput("arm_abort_same", busy, 0);

        // Constant input that never crosses the threshold
        trigLevel  = 8'd100;
        trigRising = 1'b1;
        armCapture();
`ifdef SCOPE_AUTO_TRIG_EN
        n = 0;
        while (!rdValid && n < 300) begin
            applyStimulus(8'd50);
            n++;
        end
        checkOutput("auto_reached_read", rdValid, 1);
        checkOutput("auto_trig_flag", {triggered, autoTrig}, 2'b11);
        for (int i = 0; i < NBEATS; i++) expBeats[i] = 8'd50;
        readRecord(1'b0);
`else
        seenValid = 1'b0;
        lostBusy  = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            applyStimulus(8'd50);
            if (rdValid) seenValid = 1'b1;
            if (!busy || triggered || autoTrig) lostBusy = 1'b1;
        end
        checkOutput("no_auto_valid", seenValid, 0);
        checkOutput("no_auto_waiting", lostBusy, 0);
        abort = 1'b1;
        stepCycle();
        abort = 1'b0;
        checkOutput("no_auto_abort", busy, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule

// File: doc/scope_capture_buffer.md
# scope_capture_buffer

Capture buffer that consumes the registered 8-bit sample stream from the oscilloscope input port, stores it in an internal circular RAM around a level/edge trigger, and reads the captured record back out over a valid/ready stream. It sits between the sampling front end and the host-side readout path (UART/serializer), giving one pre-/post-trigger record per arm.

## Interface
- ADDR_W, 10, log2 of record depth; DEPTH = 2**ADDR_W samples
- PRE_SAMPLES, 256, samples kept before the trigger sample; 1 ≤ PRE_SAMPLES ≤ DEPTH-1
- AUTO_TIMEOUT, 1000000, clock cycles waited for trigger before auto-trigger (used only with SCOPE_AUTO_TRIG_EN)

- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- sample_in  in  8  unsigned sample from input port
- sample_en  in  1  sample_in is a new sample this cycle (decimation strobe)
- arm  in  1  start a capture (honoured only in IDLE)
- abort  in  1  return to IDLE from any state
- trig_level  in  8  unsigned trigger threshold
- trig_rising  in  1  1 = rising-edge trigger, 0 = falling-edge
- rd_data  out  8  readout sample
- rd_valid  out  1  rd_data valid
- rd_ready  in  1  consumer accepts rd_data
- rd_last  out  1  marks final beat of record
- busy  out  1  state ≠ IDLE
- triggered  out  1  trigger has fired in current capture
- auto_trig  out  1  trigger was forced by timeout (SCOPE_AUTO_TRIG_EN only)

## Operation
- States: IDLE, PREFILL, WAIT_TRIG, POST, READ.
- IDLE: arm=1 → PREFILL; write pointer, counters, triggered, auto_trig cleared.
- PREFILL: each sample_en writes sample_in at wr_ptr, wr_ptr++ (mod DEPTH). After PRE_SAMPLES writes → WAIT_TRIG. Trigger conditions during PREFILL are ignored.
- WAIT_TRIG: each sample written; compare against previous written sample prev. Rising: prev < trig_level && cur ≥ trig_level. Falling: prev > trig_level && cur ≤ trig_level. On hit: trig_addr = address of cur, triggered=1, → POST.
- POST: write DEPTH-PRE_SAMPLES-1 further samples, then → READ. Old samples overwrite freely (circular).
- READ: emit DEPTH beats in order starting at (trig_addr - PRE_SAMPLES) mod DEPTH; trigger sample is beat index PRE_SAMPLES. rd_last=1 on beat DEPTH-1. After last beat accepted → IDLE. sample_en ignored.
- Handshake: beat transfers when rd_valid && rd_ready. While rd_valid && !rd_ready, rd_data/rd_last held stable. rd_valid never drops without a transfer except on abort/reset.
- abort: any state → IDLE next cycle; rd_valid, rd_last, busy drop that edge; triggered/auto_trig cleared. abort and arm same cycle: abort wins.
- arm outside IDLE ignored.

## Timing
- Reset: state IDLE, all pointers/counters 0; rd_data=0, rd_valid=0, rd_last=0, busy=0, triggered=0, auto_trig=0.
- busy rises the cycle after arm sampled.
- triggered rises the cycle after the triggering sample_en cycle.
- RAM is synchronous-read; first rd_valid no later than 2 cycles after entering READ.
- With rd_ready held high, one beat per cycle sustained after the first (no bubbles).
- Full record from entry to READ: ≤ DEPTH+2 cycles with rd_ready=1.

## Configuration
- SCOPE_AUTO_TRIG_EN defined: cycle counter runs in WAIT_TRIG; at AUTO_TIMEOUT cycles without a trigger, the next sample_en sample is treated as the trigger sample, auto_trig=1 (together with triggered). Counter clears on leaving WAIT_TRIG.
- Not defined: no counter, auto_trig tied 0; WAIT_TRIG waits indefinitely for a real trigger or abort.

## Test plan
- Reset mid-POST (rst_n low 1 cycle) → all outputs 0, IDLE; subsequent arm captures normally.
- ADDR_W=4, PRE_SAMPLES=4, sample_en=1, ramp 0,1,2,…, trig_level=10, trig_rising=1 → 16 beats 6..21, beat 4 = 10, rd_last only on 21.
- Same sizes, ramp 255,254,…, trig_level=100, trig_rising=0 → beats 104..89, beat 4 = 100.
- Rising ramp with threshold crossed during PREFILL (trig_level=2) → no trigger until a later crossing; verify triggered stays 0 on constant-then-rising input until crossing after prefill.
- rd_ready toggling 1/0 each cycle → rd_data stable during stalls, 16 beats in order, no drops or duplicates.
- abort in POST → busy=0 next cycle, no rd_valid; SCOPE_AUTO_TRIG_EN, AUTO_TIMEOUT=32, constant 50 → auto_trig=1, 16 beats of 50; without macro, busy stays 1 for 1000 cycles, no rd_valid.
